// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types, size codes and helpers for the memory arbiter
package mem_arbiter_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;
  localparam int         MEM_UNSIGNED  = 2;
  localparam logic [1:0] IO_REGION_DEFAULT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  // Number of byte beats for a transfer; size code 3 behaves as a word.
  function automatic logic [2:0] beat_count(input owner_t owner, input logic [1:0] size);
    logic [2:0] n;
    if (owner == OWN_INST) begin
      n = 3'd4;
    end else begin
      case (size)
        MEM_SIZE_BYTE: n = 3'd1;
        MEM_SIZE_HALF: n = 3'd2;
        default:       n = 3'd4;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and byte-bus signals of the memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  inst_valid;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic                  inst_ready;
  logic [31:0]           inst_res;
  logic                  data_valid;
  logic                  data_wr;
  logic [2:0]            data_size;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [31:0]           data_value;
  logic                  data_ready;
  logic [31:0]           data_res;
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;

  modport slave (
    input  inst_valid, inst_addr, data_valid, data_wr, data_size, data_addr, data_value,
    input  mem_din, io_buffer_full,
    output inst_ready, inst_res, data_ready, data_res, mem_dout, mem_a, mem_wr
  );

  modport master (
    output inst_valid, inst_addr, data_valid, data_wr, data_size, data_addr, data_value,
    output mem_din, io_buffer_full,
    input  inst_ready, inst_res, data_ready, data_res, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter_load_extender.sv
// rtl/mem_arbiter_load_extender.sv - sign/zero extension of assembled load data
module load_extender
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  size_i,
  output logic [31:0] data_o
);

  logic fill;

  // Extend from the top bit of the loaded width unless the unsigned flag is set.
  always_comb begin
    fill   = 1'b0;
    data_o = data_i;
    case (size_i[1:0])
      MEM_SIZE_BYTE: begin
        fill   = !size_i[MEM_UNSIGNED] && data_i[7];
        data_o = {{24{fill}}, data_i[7:0]};
      end
      MEM_SIZE_HALF: begin
        fill   = !size_i[MEM_UNSIGNED] && data_i[15];
        data_o = {{16{fill}}, data_i[15:0]};
      end
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the byte-wide memory/IO bus between fetch and load/store
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 32,
  parameter logic [1:0] IO_REGION   = IO_REGION_DEFAULT,
  parameter bit         ROUND_ROBIN = 1'b1
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          rdy_in,
  input  logic          rob_clear,
  output logic          busy,
  mem_arbiter_if.slave  arb
);

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  owner_t                last_q, last_d;
  logic                  wr_q, wr_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            size_q, size_d;
  logic [31:0]           value_q, value_d;
  logic [31:0]           buf_q, buf_d;
  logic [31:0]           inst_res_q, inst_res_d;
  logic [31:0]           data_res_q, data_res_d;

  logic [2:0]            n_beats;
  logic                  io_stall;
  logic                  grant_data;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [31:0]           value_shift;
  logic [31:0]           capture_word;
  logic [31:0]           ext_word;
  logic [ADDR_WIDTH-1:0] mem_a_c;
  logic [7:0]            mem_dout_c;
  logic                  mem_wr_c, inst_ready_c, data_ready_c;

  assign n_beats     = beat_count(owner_q, size_q[1:0]);
  assign io_stall    = (addr_q[17:16] == IO_REGION) && arb.io_buffer_full;
  assign beat_addr   = addr_q + ADDR_WIDTH'(cnt_q);
  assign value_shift = value_q >> {cnt_q[1:0], 3'b000};

  // Byte on mem_din belongs to the address issued one beat earlier.
  always_comb begin
    capture_word = buf_q;
    case (cnt_q)
      3'd1:    capture_word[7:0]   = arb.mem_din;
      3'd2:    capture_word[15:8]  = arb.mem_din;
      3'd3:    capture_word[23:16] = arb.mem_din;
      3'd4:    capture_word[31:24] = arb.mem_din;
      default: capture_word = buf_q;
    endcase
  end

  load_extender u_ext (
    .data_i (capture_word),
    .size_i (size_q),
    .data_o (ext_word)
  );

  // Arbitration, beat sequencing and bus drive.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    value_d    = value_q;
    buf_d      = buf_q;
    inst_res_d = inst_res_q;
    data_res_d = data_res_q;
    grant_data = 1'b0;
    mem_a_c      = '0;
    mem_dout_c   = '0;
    mem_wr_c     = 1'b0;
    inst_ready_c = 1'b0;
    data_ready_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rdy_in && !rob_clear && (arb.inst_valid || arb.data_valid)) begin
          grant_data = arb.data_valid &&
                       (!arb.inst_valid || !ROUND_ROBIN || last_q == OWN_INST);
          cnt_d = '0;
          buf_d = '0;
          if (grant_data) begin
            owner_d = OWN_DATA;
            wr_d    = arb.data_wr;
            addr_d  = arb.data_addr;
            size_d  = arb.data_size;
            value_d = arb.data_value;
            state_d = arb.data_wr ? ST_WRITE : ST_READ;
          end else begin
            owner_d = OWN_INST;
            wr_d    = 1'b0;
            addr_d  = arb.inst_addr;
            size_d  = {1'b0, MEM_SIZE_WORD};
            value_d = '0;
            state_d = ST_READ;
          end
          last_d = owner_d;
        end
      end
      ST_READ: begin
        if (cnt_q < n_beats) mem_a_c = beat_addr;
        if (rdy_in) begin
          if (rob_clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            if (cnt_q != 3'd0) buf_d = capture_word;
            if (cnt_q == n_beats) begin
              state_d = ST_DONE;
              cnt_d   = '0;
              if (owner_q == OWN_INST) inst_res_d = capture_word;
              else                     data_res_d = ext_word;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
      end
      ST_WRITE: begin
        mem_a_c    = beat_addr;
        mem_dout_c = value_shift[7:0];
        mem_wr_c   = rdy_in && !io_stall;
        if (rdy_in && !io_stall) begin
          if (cnt_q == n_beats - 3'd1) begin
            state_d    = ST_DONE;
            cnt_d      = '0;
            data_res_d = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_DONE: begin
        if (owner_q == OWN_INST) inst_ready_c = !rob_clear;
        else                     data_ready_c = wr_q || !rob_clear;
        if (rdy_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_INST;
      last_q     <= OWN_INST;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      value_q    <= '0;
      buf_q      <= '0;
      inst_res_q <= '0;
      data_res_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      value_q    <= value_d;
      buf_q      <= buf_d;
      inst_res_q <= inst_res_d;
      data_res_q <= data_res_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign arb.mem_a      = mem_a_c;
  assign arb.mem_dout   = mem_dout_c;
  assign arb.mem_wr     = mem_wr_c;
  assign arb.inst_ready = inst_ready_c;
  assign arb.data_ready = data_ready_c;
  assign arb.inst_res   = inst_res_q;
  assign arb.data_res   = data_res_q;

endmodule
